// File: rtl/mux_func_sweeper.sv
// mux_func_sweeper
// Sweeps the eight input combinations {A,B,C} of a 3-variable function
// through an external 4:1 mux (select = {A,B}, data = residue for C),
// captures the mux output per index and assembles the realised truth table.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         sweep request, honoured only in IDLE
//   minterms[7:0] function mask, latched on accepted start
//   mux_s[1:0]    mux select {A,B}
//   mux_D[3:0]    mux data, mux_D[j] = C ? mask[2j+1] : mask[2j]
//   mux_en        mux enable
//   mux_y         mux output
//   truth[7:0]    captured truth table
//   busy          sweep in progress
//   done          one-cycle completion pulse
//   pass          truth matches latched mask (self-check build only)
//   first_fail    lowest mismatching index (self-check build only)
//
// Build option: define SWEEP_SELFCHECK_EN to build the truth/mask comparator;
// otherwise pass and first_fail are tied to 0.
//
// state  | meaning
// IDLE   | waiting for start, mux disabled
// DRIVE  | vector for idx applied, mux settling
// SAMPLE | vector held, mux_y captured into truth[idx] at cycle end
// DONE   | done pulse, results final

module mux_func_sweeper (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] minterms,
   output logic [1:0] mux_s,
   output logic [3:0] mux_D,
   output logic       mux_en,
   input  logic       mux_y,
   output logic [7:0] truth,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] first_fail
);

   typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_SAMPLE, ST_DONE} state_t;

   state_t     state;
   logic [2:0] idx;
   logic [2:0] idx_inc;
   logic [7:0] mask_q;
   logic [7:0] truth_nxt;

   function automatic logic [3:0] residue(input logic [7:0] m, input logic c);
      logic [3:0] r;
      for (int j = 0; j < 4; j++) begin
         r[j] = c ? m[2*j+1] : m[2*j];
      end
      return r;
   endfunction

   assign idx_inc = idx + 3'd1;

   // Truth table including the bit being captured this cycle; lets the
   // comparator see the final table on the same edge that enters DONE.
   always_comb begin
      truth_nxt      = truth;
      truth_nxt[idx] = mux_y;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         idx    <= 3'd0;
         mask_q <= 8'd0;
         truth  <= 8'd0;
         mux_s  <= 2'd0;
         mux_D  <= 4'd0;
         mux_en <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mask_q <= minterms;
                  truth  <= 8'd0;
                  idx    <= 3'd0;
                  busy   <= 1'b1;
                  mux_en <= 1'b1;
                  mux_s  <= 2'd0;
                  // mask_q is not yet loaded, so index 0 uses the input directly
                  mux_D  <= residue(minterms, 1'b0);
                  state  <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               state <= ST_SAMPLE;
            end
            ST_SAMPLE: begin
               truth <= truth_nxt;
               if (idx == 3'd7) begin
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  mux_en <= 1'b0;
                  mux_s  <= 2'd0;
                  mux_D  <= 4'd0;
                  state  <= ST_DONE;
               end else begin
                  idx   <= idx_inc;
                  mux_s <= idx_inc[2:1];
                  mux_D <= residue(mask_q, idx_inc[0]);
                  state <= ST_DRIVE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SWEEP_SELFCHECK_EN
   logic [7:0] diff;
   logic [2:0] low_idx;

   assign diff = truth_nxt ^ mask_q;

   always_comb begin
      low_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (diff[i]) low_idx = 3'(i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass       <= 1'b0;
         first_fail <= 3'd0;
      end else if (state == ST_SAMPLE && idx == 3'd7) begin
         pass       <= (diff == 8'd0);
         first_fail <= low_idx;
      end
   end
`else
   assign pass       = 1'b0;
   assign first_fail = 3'd0;
`endif

endmodule
